// File: rtl/maze_mem_arbiter.sv
// Single-port maze memory arbiter: per-cycle round-robin between solver (S)
// and host (H), with an H burst lock that is broken if S starves too long.
module maze_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 1,
  parameter int MAX_WAIT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              h_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              h_owns,
  output logic              lock_broken
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT - 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t        r_state;
  logic          r_last_s;
  logic [CW-1:0] r_wait;
  logic          r_s_rvalid;
  logic          r_h_rvalid;
  logic          r_lock_broken;

  logic w_s_gnt;
  logic w_h_gnt;
  logic w_brk;

  // In LOCK only H is served, except when S has waited the full bound.
  always_comb begin
    w_brk   = 1'b0;
    w_s_gnt = 1'b0;
    w_h_gnt = 1'b0;
    if (r_state == ARB) begin
      w_s_gnt = s_req && (!h_req || !r_last_s);
      w_h_gnt = h_req && (!s_req ||  r_last_s);
    end else begin
      w_brk   = s_req && (r_wait == WAIT_MAX);
      w_s_gnt = w_brk;
      w_h_gnt = h_req && !w_brk;
    end
  end

  assign s_gnt     = w_s_gnt;
  assign h_gnt     = w_h_gnt;
  assign mem_en    = w_s_gnt | w_h_gnt;
  assign mem_we    = (w_s_gnt & s_we) | (w_h_gnt & h_we);
  assign mem_addr  = w_h_gnt ? h_addr  : s_addr;
  assign mem_wdata = w_h_gnt ? h_wdata : s_wdata;

  assign s_rvalid    = r_s_rvalid;
  assign h_rvalid    = r_h_rvalid;
  assign s_rdata     = mem_rdata;
  assign h_rdata     = mem_rdata;
  assign h_owns      = (r_state == LOCK);
  assign lock_broken = r_lock_broken;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ARB;
      r_last_s      <= 1'b0;
      r_wait        <= '0;
      r_s_rvalid    <= 1'b0;
      r_h_rvalid    <= 1'b0;
      r_lock_broken <= 1'b0;
    end else begin
      r_s_rvalid    <= w_s_gnt & ~s_we;
      r_h_rvalid    <= w_h_gnt & ~h_we;
      r_lock_broken <= w_brk;
      if (w_s_gnt)      r_last_s <= 1'b1;
      else if (w_h_gnt) r_last_s <= 1'b0;
      case (r_state)
        ARB: begin
          r_wait <= '0;
          if (w_h_gnt && h_lock) r_state <= LOCK;
        end
        LOCK: begin
          // The release cycle still counts S waiting; the count is dropped on exit.
          if (w_brk || !h_lock) begin
            r_state <= ARB;
            r_wait  <= '0;
          end else if (s_req && r_wait != WAIT_MAX) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed scenarios then random traffic, all
// checked cycle by cycle against a rule-level model with its own memory image.
module tb_maze_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 1;
  localparam int MW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          s_req = 0, s_we = 0, h_req = 0, h_we = 0, h_lock = 0;
  logic [AW-1:0] s_addr = 0, h_addr = 0;
  logic [DW-1:0] s_wdata = 0, h_wdata = 0;
  logic          s_gnt, s_rvalid, h_gnt, h_rvalid, mem_en, mem_we, h_owns, lock_broken;
  logic [DW-1:0] s_rdata, h_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = 0;
  logic [AW-1:0] mem_addr;

  maze_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .h_lock(h_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .h_owns(h_owns), .lock_broken(lock_broken)
  );

  always #5 CLK = ~CLK;

  // Memory attached to the DUT: single port, 1-cycle read latency.
  logic [DW-1:0] envmem [256];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) envmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= envmem[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the memory, whose turn it is, how long S waited.
  logic [DW-1:0] refmem [256];
  bit m_lock, m_last_s, m_srv, m_hrv, m_brk;
  int m_wait;
  logic [DW-1:0] m_sdat, m_hdat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_last_s = 0; m_wait = 0;
    m_srv = 0; m_hrv = 0; m_brk = 0;
  endtask

  // One clock cycle: inputs are already set (just after a negedge).
  task automatic cyc();
    bit es, eh, brk, ewe;
    #2;
    brk = m_lock && s_req && (m_wait == MW - 1);
    if (!m_lock) begin
      es = s_req && (!h_req || !m_last_s);
      eh = h_req && !es;
    end else begin
      es = brk;
      eh = h_req && !brk;
    end
    ewe = (es && s_we) || (eh && h_we);
    chk("s_gnt", 32'(s_gnt), 32'(es));
    chk("h_gnt", 32'(h_gnt), 32'(eh));
    chk("mem_en", 32'(mem_en), 32'(es || eh));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    if (es || eh) chk("mem_addr", 32'(mem_addr), 32'(eh ? h_addr : s_addr));
    if (ewe) chk("mem_wdata", 32'(mem_wdata), 32'(eh ? h_wdata : s_wdata));
    chk("h_owns", 32'(h_owns), 32'(m_lock));
    chk("lock_broken", 32'(lock_broken), 32'(m_brk));
    chk("s_rvalid", 32'(s_rvalid), 32'(m_srv));
    chk("h_rvalid", 32'(h_rvalid), 32'(m_hrv));
    if (m_srv) chk("s_rdata", 32'(s_rdata), 32'(m_sdat));
    if (m_hrv) chk("h_rdata", 32'(h_rdata), 32'(m_hdat));
    @(posedge CLK);
    m_srv = es && !s_we;
    m_hrv = eh && !h_we;
    if (m_srv) m_sdat = refmem[s_addr];
    if (m_hrv) m_hdat = refmem[h_addr];
    if (es && s_we) refmem[s_addr] = s_wdata;
    if (eh && h_we) refmem[h_addr] = h_wdata;
    m_brk = brk;
    if (!m_lock) begin
      m_lock = eh && h_lock;
      m_wait = 0;
    end else if (brk || !h_lock) begin
      m_lock = 0;
      m_wait = 0;
    end else if (s_req && m_wait < MW - 1) begin
      m_wait++;
    end
    if (es) m_last_s = 1;
    else if (eh) m_last_s = 0;
    @(negedge CLK);
    if (es) s_req = 0;
    if (eh) h_req = 0;
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_s_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
    chk("rst_h_owns", 32'(h_owns), 32'd0);
    chk("rst_lock_broken", 32'(lock_broken), 32'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic set_s(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_req = 1; s_we = we; s_addr = a; s_wdata = d;
  endtask

  task automatic set_h(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_req = 1; h_we = we; h_addr = a; h_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      refmem[i] = DW'($urandom);
      envmem[i] = refmem[i];
    end
    refmem[8'h21] = 1; envmem[8'h21] = 1;
    model_reset();
    @(negedge CLK);
    chk("reset_s_gnt", 32'(s_gnt), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_h_owns", 32'(h_owns), 32'd0);
    chk("reset_s_rvalid", 32'(s_rvalid), 32'd0);
    RST = 1'b0;

    // S read straight out of reset, data one cycle later
    set_s(0, 8'h21, 0);
    cyc();
    cyc();

    // Contention held for four cycles: grants alternate
    for (int i = 0; i < 4; i++) begin
      set_s(0, AW'(8'h30 + i), 0);
      set_h(0, AW'(8'h40 + i), 0);
      cyc();
    end
    s_req = 0; h_req = 0;
    cyc();

    // H takes the lock, S starves until the wait bound breaks it
    h_lock = 1;
    set_h(1, 8'h10, 1);
    cyc();
    set_s(0, 8'h10, 0);
    for (int i = 0; i < MW; i++) begin
      set_h(1, AW'(8'h11 + i), DW'(i));
      cyc();
    end
    h_req = 0; h_lock = 0;
    cyc();
    cyc();

    // H write under lock, release, S read of the same cell
    h_lock = 1;
    set_h(1, 8'h00, 1);
    cyc();
    h_lock = 0;
    set_s(0, 8'h00, 0);
    cyc();
    cyc();
    cyc();

    // Reset lands while an H read response is pending
    set_h(0, 8'h21, 0);
    cyc();
    do_reset();
    set_s(0, 8'h05, 0);
    set_h(0, 8'h06, 0);
    cyc();
    set_h(0, 8'h06, 0);
    cyc();
    cyc();

    // Lock level without an H request does nothing
    h_lock = 1;
    set_s(1, 8'h07, 1);
    cyc();
    cyc();
    h_lock = 0;
    cyc();

    // Random traffic: requesters hold until granted, lock toggles now and then
    for (int n = 0; n < 600; n++) begin
      if (!s_req && $urandom_range(0, 2) == 0)
        set_s(1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
      if (!h_req && $urandom_range(0, 1) == 0)
        set_h(1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
      if ($urandom_range(0, 9) == 0) h_lock = ~h_lock;
      if (n == 300) do_reset();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
